uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter NB_DATA, default 8: data bits per frame, legal range 5..8.
REQ-002 Parameter N_TICKS, default 16: oversampling ticks per bit, even, legal range 8..32.
REQ-003 Parameter NB_TICK_CNT, default 5: tick counter width; SHALL satisfy 2^NB_TICK_CNT >= N_TICKS.
REQ-004 i_clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_s_tick  in  1  baud-rate oversampling strobe, one i_clock wide, N_TICKS per bit.
REQ-007 i_rx  in  1  asynchronous serial line, idle high.
REQ-008 i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 i_stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
REQ-010 o_data  out  NB_DATA  last received word, LSB first on the line, bit0 = first data bit.
REQ-011 o_rx_done_tick  out  1  one-i_clock pulse per completed frame.
REQ-012 o_parity_err  out  1  parity mismatch for the last frame.
REQ-013 o_frame_err  out  1  a stop bit sampled low in the last frame.
REQ-014 o_break  out  1  break condition detected in the last frame.

Function
REQ-015 i_rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-017 i_parity_mode and i_stop_bits SHALL be latched on the IDLE->START transition; changes mid-frame have no effect.
REQ-018 IDLE: on an i_s_tick with synchronized rx = 0, go to START and clear the tick counter.
REQ-019 Bit value = majority of the three samples at ticks N_TICKS/2-1, N_TICKS/2 and N_TICKS/2+1 of that bit; the tick counter wraps to 0 after tick N_TICKS-1.
REQ-020 START: if the majority value is 1, the start is false; return to IDLE with no output change.
REQ-021 START: otherwise go to DATA at the end of the start bit.
REQ-022 DATA: shift NB_DATA majority bits in LSB-first, then go to PARITY if parity is enabled, else to STOP.
REQ-023 PARITY: compare the sampled bit with the XOR of the data (even) or its inverse (odd); a mismatch sets the pending parity error.
REQ-024 STOP: sample one or two stop bits; any low majority sets the pending frame error.
REQ-025 STOP: the frame completes at the mid-sample (tick N_TICKS/2+1) of the last stop bit, not at the bit end, to allow resynchronization.
REQ-026 Completion: on the i_clock cycle after the completing i_s_tick, assert o_rx_done_tick for exactly one cycle.
REQ-027 Completion: in that same cycle, update o_data, o_parity_err, o_frame_err and o_break; hold them until the next completion.
REQ-028 Break: data all 0, parity bit 0 (if enabled) and first stop bit 0 SHALL set o_break=1 and o_frame_err=1, with o_data=0.
REQ-029 Break: after a break, enter BRK_WAIT and return to IDLE only on an i_s_tick with rx = 1; no new frame starts while in BRK_WAIT.
REQ-030 Non-break frame with frame error: return to IDLE directly.
REQ-031 Without i_s_tick, no counter or state advances; outputs other than the done pulse stay static.
REQ-032 IDLE with rx = 1 SHALL be stable indefinitely.

Reset
REQ-033 When i_reset=0, immediately: state IDLE, counters 0, shift register 0, synchronizer flops 1.
REQ-034 When i_reset=0, immediately: o_data=0, o_rx_done_tick=0, all error flags 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; no done pulse until a complete new frame is received after reset release.

Verification (N_TICKS=16, NB_DATA=8)
REQ-036 Frame 0x55, parity none, 1 stop -> exactly one done pulse, o_data=0x55, all error flags 0.
REQ-037 Frame 0xA3, even parity, parity bit sent as 1 -> o_data=0xA3, o_parity_err=1, o_frame_err=0.
REQ-038 Frame 0x0F, 2 stops, second stop bit driven 0 -> o_frame_err=1, o_break=0, o_data=0x0F.
REQ-039 Line low for 12 bit times, then high -> one done pulse, o_break=1, o_frame_err=1, o_data=0x00; no second pulse before the line returns high.
REQ-040 Start glitch low for 4 ticks; single-tick glitch at mid data bit 3 of frame 0xC6 -> no done pulse for the start glitch; the frame still yields 0xC6.
REQ-041 Reset asserted during data bit 4, released, then frame 0x3C -> outputs 0 during reset; one pulse with 0x3C afterwards.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Serial-receiver bus: line, oversampling strobe, frame config and received-word results.
interface uart_rx_cfg_if #(
  parameter int unsigned NB_DATA = 8
);

  logic               i_s_tick;
  logic               i_rx;
  logic [1:0]         i_parity_mode;
  logic               i_stop_bits;
  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done_tick;
  logic               o_parity_err;
  logic               o_frame_err;
  logic               o_break;

  // Side that drives the line and config, and consumes received words.
  modport master (
    output i_s_tick, i_rx, i_parity_mode, i_stop_bits,
    input  o_data, o_rx_done_tick, o_parity_err, o_frame_err, o_break
  );

  // Receiver side.
  modport slave (
    input  i_s_tick, i_rx, i_parity_mode, i_stop_bits,
    output o_data, o_rx_done_tick, o_parity_err, o_frame_err, o_break
  );

endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime parity/stop configuration,
// majority-vote bit sampling, frame/parity error and break detection.
module uart_rx_cfg #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned N_TICKS     = 16,
  parameter int unsigned NB_TICK_CNT = 5
) (
  input  logic          i_clock,
  input  logic          i_reset,
  uart_rx_cfg_if.slave  bus
);

  localparam int unsigned MID        = N_TICKS / 2;
  localparam int unsigned NB_BIT_CNT = 3;

  localparam logic [NB_TICK_CNT-1:0] T_S0  = NB_TICK_CNT'(MID - 1);
  localparam logic [NB_TICK_CNT-1:0] T_S1  = NB_TICK_CNT'(MID);
  localparam logic [NB_TICK_CNT-1:0] T_S2  = NB_TICK_CNT'(MID + 1);
  localparam logic [NB_TICK_CNT-1:0] T_END = NB_TICK_CNT'(N_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  state_t               state, state_n;
  logic [NB_TICK_CNT-1:0] cnt, cnt_n;
  logic [NB_BIT_CNT-1:0]  bit_cnt, bit_cnt_n;
  logic [NB_DATA-1:0]     shreg, shreg_n;
  logic [1:0]             samp, samp_n;
  logic                   par_en, par_en_n;
  logic                   par_odd, par_odd_n;
  logic                   two_stop, two_stop_n;
  logic                   par_err_p, par_err_p_n;
  logic                   frm_err_p, frm_err_p_n;
  logic                   par_bit, par_bit_n;
  logic                   stop0, stop0_n;
  logic [NB_DATA-1:0]     data_q, data_n;
  logic                   done_q, done_n;
  logic                   par_err_q, par_err_n;
  logic                   frm_err_q, frm_err_n;
  logic                   brk_q, brk_n;

  logic rx_meta, rx_sync;
  logic tick, maj, sample_pt, bit_end;
  logic frm_now, stop0_now, is_brk;

  // Two-flop synchronizer for the asynchronous line (idle high).
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick      = bus.i_s_tick;
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
  assign sample_pt = tick && (cnt == T_S2);
  assign bit_end   = tick && (cnt == T_END);

  // Next-state and datapath: tick counting, majority sampling, frame assembly, completion.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    samp_n      = samp;
    par_en_n    = par_en;
    par_odd_n   = par_odd;
    two_stop_n  = two_stop;
    par_err_p_n = par_err_p;
    frm_err_p_n = frm_err_p;
    par_bit_n   = par_bit;
    stop0_n     = stop0;
    data_n      = data_q;
    done_n      = 1'b0;
    par_err_n   = par_err_q;
    frm_err_n   = frm_err_q;
    brk_n       = brk_q;
    frm_now     = frm_err_p | ~maj;
    stop0_now   = (bit_cnt == '0) ? maj : stop0;
    is_brk      = (shreg == '0) && (!par_en || !par_bit) && !stop0_now;

    if (tick && state != IDLE && state != BRK_WAIT) begin
      cnt_n = bit_end ? '0 : cnt + NB_TICK_CNT'(1);
      if (cnt == T_S0) samp_n[0] = rx_sync;
      if (cnt == T_S1) samp_n[1] = rx_sync;
    end

    case (state)
      IDLE: begin
        if (tick && !rx_sync) begin
          state_n     = START;
          cnt_n       = '0;
          bit_cnt_n   = '0;
          par_en_n    = (bus.i_parity_mode == 2'b01) || (bus.i_parity_mode == 2'b10);
          par_odd_n   = (bus.i_parity_mode == 2'b10);
          two_stop_n  = bus.i_stop_bits;
          par_err_p_n = 1'b0;
          frm_err_p_n = 1'b0;
          par_bit_n   = 1'b0;
          stop0_n     = 1'b1;
        end
      end
      START: begin
        if (sample_pt && maj) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (sample_pt) shreg_n = {maj, shreg[NB_DATA-1:1]};
        if (bit_end) begin
          if (bit_cnt == NB_BIT_CNT'(NB_DATA - 1)) begin
            bit_cnt_n = '0;
            state_n   = par_en ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + NB_BIT_CNT'(1);
          end
        end
      end
      PARITY: begin
        if (sample_pt) begin
          par_bit_n = maj;
          if (maj != ((^shreg) ^ par_odd)) par_err_p_n = 1'b1;
        end
        if (bit_end) begin
          state_n   = STOP;
          bit_cnt_n = '0;
        end
      end
      STOP: begin
        if (sample_pt) begin
          frm_err_p_n = frm_now;
          stop0_n     = stop0_now;
          // Complete at mid-sample of the last stop bit to leave room for resync.
          if (!two_stop || bit_cnt != '0) begin
            done_n    = 1'b1;
            data_n    = shreg;
            par_err_n = par_err_p;
            frm_err_n = frm_now;
            brk_n     = is_brk;
            state_n   = is_brk ? BRK_WAIT : IDLE;
            cnt_n     = '0;
          end
        end else if (bit_end) begin
          bit_cnt_n = bit_cnt + NB_BIT_CNT'(1);
        end
      end
      BRK_WAIT: begin
        if (tick && rx_sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      samp      <= '0;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      two_stop  <= 1'b0;
      par_err_p <= 1'b0;
      frm_err_p <= 1'b0;
      par_bit   <= 1'b0;
      stop0     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      samp      <= samp_n;
      par_en    <= par_en_n;
      par_odd   <= par_odd_n;
      two_stop  <= two_stop_n;
      par_err_p <= par_err_p_n;
      frm_err_p <= frm_err_p_n;
      par_bit   <= par_bit_n;
      stop0     <= stop0_n;
      data_q    <= data_n;
      done_q    <= done_n;
      par_err_q <= par_err_n;
      frm_err_q <= frm_err_n;
      brk_q     <= brk_n;
    end
  end

  assign bus.o_data         = data_q;
  assign bus.o_rx_done_tick = done_q;
  assign bus.o_parity_err   = par_err_q;
  assign bus.o_frame_err    = frm_err_q;
  assign bus.o_break        = brk_q;

endmodule
